gb_chan_array: RTL

//  Parametrised host-bus slave replicating CHANNELS identical channel slices (control reg, event counter, ID,

---
 rtl/gb_chan_pkg.sv | 33 +++
 rtl/gb_chan_slice.sv | 83 ++++++++
 rtl/gb_chan_array.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gb_chan_pkg.sv
// Shared definitions for the ghostbus channel array: local register offsets,
// CTRL bit positions, register-select encoding and elaboration-time helpers.
package gb_chan_pkg;

    localparam int OFF_CTRL  = 0;
    localparam int OFF_COUNT = 1;
    localparam int OFF_ID    = 2;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    typedef enum logic [1:0] {
        SEL_CTRL,
        SEL_COUNT,
        SEL_ID,
        SEL_RAM
    } reg_sel_e;

    // The RAM window starts at the midpoint of the per-channel offset space.
    function automatic int gb_ram_base(input int ch_lsb);
        return 1 << (ch_lsb - 1);
    endfunction

    // Ceiling log2, never less than 1 so a single channel still gets a select bit.
    function automatic int gb_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/gb_chan_slice.sv
// One channel slice: CTRL register, event counter, ID, byte-wide scratch RAM and
// a registered read port that zeroes itself on other channels' reads (OR-mux friendly).
module gb_chan_slice
    import gb_chan_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RAM_AW = 3,
    parameter int CNT_W  = 16,
    parameter int CH_IDX = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wen_i,
    input  logic              rd_any_i,
    input  logic              rd_sel_i,
    input  reg_sel_e          kind_i,
    input  logic [RAM_AW-1:0] ram_idx_i,
    input  logic [7:0]        wdata_i,
    input  logic              tick_i,
    output logic              en_o,
    output logic [DW-1:0]     rdata_o
);

    logic             en_q, en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [DW-1:0]    rd_val;
    logic             ctrl_wr;
    logic             clr;
    logic [7:0]       ram_q [2**RAM_AW];

    always_comb begin
        ctrl_wr = wen_i && (kind_i == SEL_CTRL);
        clr     = ctrl_wr && wdata_i[CTRL_CLR];
        en_d    = ctrl_wr ? wdata_i[CTRL_EN] : en_q;
        // A clear beats a coincident tick; counting uses the enable held before the write.
        if (clr) begin
            cnt_d = '0;
        end else if (en_q && tick_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_comb begin
        rd_val = '0;
        case (kind_i)
            SEL_CTRL:  rd_val = DW'(en_q);
            SEL_COUNT: rd_val = DW'(cnt_q);
            SEL_ID:    rd_val = DW'(CH_IDX);
            SEL_RAM:   rd_val = DW'(ram_q[ram_idx_i]);
            default:   rd_val = '0;
        endcase
        if (rd_any_i) begin
            rdata_d = rd_sel_i ? rd_val : '0;
        end else begin
            rdata_d = rdata_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wen_i && (kind_i == SEL_RAM)) begin
            ram_q[ram_idx_i] <= wdata_i;
        end
    end

    assign en_o    = en_q;
    assign rdata_o = rdata_q;

endmodule

// File: rtl/gb_chan_array.sv
// Ghostbus slave holding CHANNELS identical channel slices: address decode,
// per-channel strobe qualification, read OR-mux, read-latency pipeline and error pulse.
module gb_chan_array
    import gb_chan_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int AW       = 24,
    parameter int DW       = 32,
    parameter int CH_LSB   = 8,
    parameter int RAM_AW   = 3,
    parameter int CNT_W    = 16,
    parameter int RD       = 2
) (
    input  logic                gb_clk,
    input  logic                gb_rst,
    input  logic [AW-1:0]       gb_addr,
    input  logic [DW-1:0]       gb_wdata,
    input  logic                gb_wen,
    input  logic                gb_rstb,
    output logic [DW-1:0]       gb_rdata,
    output logic                gb_rvalid,
    output logic                gb_err,
    input  logic [CHANNELS-1:0] ch_tick,
    output logic [CHANNELS-1:0] ch_en
);

    localparam int CHW      = gb_clog2(CHANNELS);
    localparam int RAM_BASE = gb_ram_base(CH_LSB);
    localparam logic [CH_LSB-1:0] RAM_TAG = CH_LSB'(RAM_BASE >> RAM_AW);

    logic [CHW-1:0]      ch;
    logic [CH_LSB-1:0]   off;
    logic [CHANNELS-1:0] ch_hit;
    reg_sel_e            kind;
    logic                off_ok, upper_ok, mapped;
    logic                vld1_q, err_q, err_d;
    logic [DW-1:0]       rd_or;
    logic [DW-1:0]       slice_rdata [CHANNELS];
    logic                wdata_unused;

    assign ch           = gb_addr[CH_LSB +: CHW];
    assign off          = gb_addr[CH_LSB-1:0];
    assign upper_ok     = (gb_addr >> (CH_LSB + CHW)) == '0;
    assign mapped       = upper_ok && off_ok && (|ch_hit);
    assign wdata_unused = ^gb_wdata[DW-1:8];

    always_comb begin
        kind   = SEL_CTRL;
        off_ok = 1'b1;
        if (off == CH_LSB'(OFF_CTRL)) begin
            kind = SEL_CTRL;
        end else if (off == CH_LSB'(OFF_COUNT)) begin
            kind = SEL_COUNT;
        end else if (off == CH_LSB'(OFF_ID)) begin
            kind = SEL_ID;
        end else if ((off >> RAM_AW) == RAM_TAG) begin
            kind = SEL_RAM;
        end else begin
            off_ok = 1'b0;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign ch_hit[i] = (ch == CHW'(i));

        gb_chan_slice #(
            .DW     (DW),
            .RAM_AW (RAM_AW),
            .CNT_W  (CNT_W),
            .CH_IDX (i)
        ) u_slice (
            .clk_i     (gb_clk),
            .rst_i     (gb_rst),
            .wen_i     (gb_wen && mapped && ch_hit[i]),
            .rd_any_i  (gb_rstb),
            .rd_sel_i  (gb_rstb && mapped && ch_hit[i]),
            .kind_i    (kind),
            .ram_idx_i (off[RAM_AW-1:0]),
            .wdata_i   (gb_wdata[7:0]),
            .tick_i    (ch_tick[i]),
            .en_o      (ch_en[i]),
            .rdata_o   (slice_rdata[i])
        );
    end

    // Every slice drives zero unless it owns the latest read, so OR is a mux.
    always_comb begin
        rd_or = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rd_or = rd_or | slice_rdata[i];
        end
    end

    assign err_d = (gb_wen || gb_rstb) && !mapped;

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            vld1_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            vld1_q <= gb_rstb;
            err_q  <= err_d;
        end
    end

    assign gb_err = err_q;

    if (RD == 1) begin : g_rd1
        assign gb_rdata  = rd_or;
        assign gb_rvalid = vld1_q;
    end else begin : g_rdn
        logic [DW-1:0] dat_q [RD-1];
        logic [RD-2:0] vld_q;

        // Inner stages shift freely; the last stage loads only on valid so gb_rdata holds.
        always_ff @(posedge gb_clk) begin
            if (gb_rst) begin
                vld_q <= '0;
                for (int i = 0; i < RD - 1; i++) dat_q[i] <= '0;
            end else begin
                vld_q <= (vld_q << 1) | (RD-1)'(vld1_q);
                for (int i = RD - 2; i > 0; i--) begin
                    if ((i < RD - 2) || vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                end
                if ((RD - 2 > 0) || vld1_q) dat_q[0] <= rd_or;
            end
        end

        assign gb_rdata  = dat_q[RD-2];
        assign gb_rvalid = vld_q[RD-2];
    end

endmodule
